gam_node_counter_bank: RTL and testbench

Per-class node occupancy counter for the GAM memory layer, replacing the single-class, edge-triggered node counter with a clocked bank of `NUM_CLASSES` saturating counters. The learning path adds nodes and the pruning path removes them, both through independent one-cycle strobes. A registered query port reports one class's count and full status. A sequenced clear-all sweep resets every class between training epochs.

---
 rtl/gam_node_counter_bank_pkg.sv | 20 ++
 rtl/gam_node_counter_bank_cell.sv | 40 ++++
 rtl/gam_node_counter_bank.sv | 193 +++++++++++++++++++
 tb/tb_gam_node_counter_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gam_node_counter_bank_pkg.sv
// GAM_package: shared definitions for the GAM node occupancy counter bank.
//   gam_node_cnt_state_e : sweep FSM states (IDLE, SWEEP)
//   GAM_NUM_CLASSES      : default number of classes
//   GAM_MAX_NODES        : default per-class node cap
//   GAM_CNT_W            : default per-class counter width
//   gam_node_cnt_arr_t   : packed count array sized by the defaults above
package GAM_package;

  localparam int GAM_NUM_CLASSES = 16;
  localparam int GAM_MAX_NODES   = 200;
  localparam int GAM_CNT_W       = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } gam_node_cnt_state_e;

  typedef logic [GAM_NUM_CLASSES-1:0][GAM_CNT_W-1:0] gam_node_cnt_arr_t;

endpackage

// File: rtl/gam_node_counter_bank_cell.sv
// gam_node_cnt_cell: one saturating per-class node counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (sweep)
//   inc, dec : one-cycle strobes; both together are a net no-op
//   count    : current count
//   full     : count == MAX_NODES
//   zero     : count == 0
module gam_node_cnt_cell
  import GAM_package::*;
#(
  parameter int CNT_W     = GAM_CNT_W,
  parameter int MAX_NODES = GAM_MAX_NODES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             zero
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_NODES);

  assign full = (count == MAX_C);
  assign zero = (count == '0);

  // Saturating at both ends: a refused step leaves the count untouched.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/gam_node_counter_bank.sv
// gam_node_counter_bank: bank of NUM_CLASSES saturating node counters with a
// registered query port and a one-class-per-cycle clear-all sweep.
//   clk, rst                  : clock, synchronous active-high reset
//   inc_en/inc_class          : add one node to a class
//   dec_en/dec_class          : remove one node from a class
//   clr_all                   : start the clear sweep (IDLE only)
//   busy                      : sweep in progress
//   inc_ack/inc_nack          : registered pulse, increment applied/refused
//   err_underflow             : registered pulse, decrement of an empty class
//   q_en/q_class              : query strobe and class
//   q_valid/q_count/q_full    : registered query result (1-cycle latency)
//   total_count               : sum of all counts, only when
//                               GAM_NODE_CNT_TOTAL_EN is defined
module gam_node_counter_bank
  import GAM_package::*;
#(
  parameter int NUM_CLASSES = GAM_NUM_CLASSES,
  parameter int CNT_W       = GAM_CNT_W,
  parameter int MAX_NODES   = GAM_MAX_NODES,
  parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_en,
  input  logic [CLS_W-1:0]       inc_class,
  input  logic                   dec_en,
  input  logic [CLS_W-1:0]       dec_class,
  input  logic                   clr_all,
  output logic                   busy,
  output logic                   inc_ack,
  output logic                   inc_nack,
  output logic                   err_underflow,
  input  logic                   q_en,
  input  logic [CLS_W-1:0]       q_class,
  output logic                   q_valid,
  output logic [CNT_W-1:0]       q_count,
  output logic                   q_full
`ifdef GAM_NODE_CNT_TOTAL_EN
  ,
  output logic [CNT_W+CLS_W-1:0] total_count
`endif
);

  gam_node_cnt_state_e state;
  logic [CLS_W-1:0]    ptr;
  logic                idle;

  logic [NUM_CLASSES-1:0]            inc_hit;
  logic [NUM_CLASSES-1:0]            dec_hit;
  logic [NUM_CLASSES-1:0]            clr_hit;
  logic [NUM_CLASSES-1:0]            full_vec;
  logic [NUM_CLASSES-1:0]            zero_vec;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;

  logic             inc_ack_d;
  logic             inc_nack_d;
  logic             underflow_d;
  logic [CNT_W-1:0] q_sel_cnt;
  logic             q_sel_full;

  assign idle = (state == IDLE);

  // Strobes only reach a cell in IDLE; an out-of-range index matches no cell,
  // so it is refused (inc) or dropped (dec) without extra range logic.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cell
    assign inc_hit[gi] = inc_en && idle && (inc_class == CLS_W'(gi));
    assign dec_hit[gi] = dec_en && idle && (dec_class == CLS_W'(gi));
    assign clr_hit[gi] = !idle && (ptr == CLS_W'(gi));

    gam_node_cnt_cell #(
      .CNT_W     (CNT_W),
      .MAX_NODES (MAX_NODES)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_hit[gi]),
      .inc   (inc_hit[gi]),
      .dec   (dec_hit[gi]),
      .count (cnt[gi]),
      .full  (full_vec[gi]),
      .zero  (zero_vec[gi])
    );
  end

  // A same-class inc+dec is always acknowledged, even at 0 or at the cap.
  assign inc_ack_d   = |(inc_hit & (dec_hit | ~full_vec));
  assign inc_nack_d  = inc_en & ~inc_ack_d;
  assign underflow_d = |(dec_hit & ~inc_hit & zero_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_ack       <= 1'b0;
      inc_nack      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      inc_ack       <= inc_ack_d;
      inc_nack      <= inc_nack_d;
      err_underflow <= underflow_d;
    end
  end

  // Sweep FSM: busy is registered alongside the state so it follows it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_all) begin
            state <= SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr == CLS_W'(NUM_CLASSES - 1)) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Query mux reads pre-update contents; out-of-range classes read 0 / not full.
  always_comb begin
    q_sel_cnt  = '0;
    q_sel_full = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (q_class == CLS_W'(i)) begin
        q_sel_cnt  = cnt[i];
        q_sel_full = full_vec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_count <= '0;
      q_full  <= 1'b0;
    end else begin
      q_valid <= q_en;
      if (q_en) begin
        q_count <= q_sel_cnt;
        q_full  <= q_sel_full;
      end
    end
  end

`ifdef GAM_NODE_CNT_TOTAL_EN
  localparam int TOT_W = CNT_W + CLS_W;

  logic             net_inc;
  logic             net_dec;
  logic [CNT_W-1:0] sweep_cnt;

  assign net_inc = |(inc_hit & ~dec_hit & ~full_vec);
  assign net_dec = |(dec_hit & ~inc_hit & ~zero_vec);

  always_comb begin
    sweep_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (ptr == CLS_W'(i)) begin
        sweep_cnt = cnt[i];
      end
    end
  end

  // Tracks the counters incrementally; the sweep subtracts each class as it
  // is zeroed, so the total reaches 0 on the last sweep cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_count <= '0;
    end else if (!idle) begin
      total_count <= total_count - TOT_W'(sweep_cnt);
    end else begin
      total_count <= total_count + TOT_W'(net_inc) - TOT_W'(net_dec);
    end
  end
`endif

endmodule

// File: tb/tb_gam_node_counter_bank.sv
// Self-checking bench for gam_node_counter_bank (default parameters).
// Query results are predicted into a queue when q_en is driven and popped
// when q_valid appears; status pulses and busy are checked every cycle.
module tb_gam_node_counter_bank;

  localparam int NC   = 16;
  localparam int MAXN = 200;
  localparam int CW   = 8;
  localparam int CLW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            inc_en;
  logic [CLW-1:0]  inc_class;
  logic            dec_en;
  logic [CLW-1:0]  dec_class;
  logic            clr_all;
  logic            busy;
  logic            inc_ack;
  logic            inc_nack;
  logic            err_underflow;
  logic            q_en;
  logic [CLW-1:0]  q_class;
  logic            q_valid;
  logic [CW-1:0]   q_count;
  logic            q_full;
`ifdef GAM_NODE_CNT_TOTAL_EN
  logic [CW+CLW-1:0] total_count;
`endif

  always #5 clk = ~clk;

  gam_node_counter_bank dut (
    .clk           (clk),
    .rst           (rst),
    .inc_en        (inc_en),
    .inc_class     (inc_class),
    .dec_en        (dec_en),
    .dec_class     (dec_class),
    .clr_all       (clr_all),
    .busy          (busy),
    .inc_ack       (inc_ack),
    .inc_nack      (inc_nack),
    .err_underflow (err_underflow),
    .q_en          (q_en),
    .q_class       (q_class),
    .q_valid       (q_valid),
    .q_count       (q_count),
    .q_full        (q_full)
`ifdef GAM_NODE_CNT_TOTAL_EN
    ,
    .total_count   (total_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mcnt [NC];
  bit mbusy;
  int mptr;
  int mtotal;
  int last_qc;
  bit last_qf;

  typedef struct {
    int cnt;
    bit full;
  } qexp_t;
  qexp_t qq[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check the DUT.
  task automatic step(input bit r, input bit ie, input int ic, input bit de, input int dc,
                      input bit cl, input bit qe, input int qc);
    bit    eack  = 1'b0;
    bit    enack = 1'b0;
    bit    euf   = 1'b0;
    qexp_t e;
    rst       = r;
    inc_en    = ie;
    inc_class = ic[CLW-1:0];
    dec_en    = de;
    dec_class = dc[CLW-1:0];
    clr_all   = cl;
    q_en      = qe;
    q_class   = qc[CLW-1:0];

    if (r) begin
      for (int i = 0; i < NC; i++) mcnt[i] = 0;
      mbusy   = 1'b0;
      mptr    = 0;
      mtotal  = 0;
      last_qc = 0;
      last_qf = 1'b0;
      qq.delete();
    end else begin
      if (qe) begin
        e.cnt  = (qc < NC) ? mcnt[qc] : 0;
        e.full = (e.cnt == MAXN);
        qq.push_back(e);
      end
      if (mbusy) begin
        if (ie) enack = 1'b1;
        mtotal -= mcnt[mptr];
        mcnt[mptr] = 0;
        if (mptr == NC - 1) begin
          mbusy = 1'b0;
          mptr  = 0;
        end else begin
          mptr++;
        end
      end else begin
        if (ie && de && ic == dc && ic < NC) begin
          eack = 1'b1;
        end else begin
          if (ie) begin
            if (ic < NC && mcnt[ic] < MAXN) begin
              mcnt[ic]++;
              mtotal++;
              eack = 1'b1;
            end else begin
              enack = 1'b1;
            end
          end
          if (de && dc < NC) begin
            if (mcnt[dc] > 0) begin
              mcnt[dc]--;
              mtotal--;
            end else begin
              euf = 1'b1;
            end
          end
        end
        if (cl) begin
          mbusy = 1'b1;
          mptr  = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    check("inc_ack", inc_ack, eack);
    check("inc_nack", inc_nack, enack);
    check("err_underflow", err_underflow, euf);
    check("busy", busy, mbusy);
    check("q_valid", q_valid, qe && !r);
    if (q_valid) begin
      if (qq.size() > 0) begin
        e       = qq.pop_front();
        last_qc = e.cnt;
        last_qf = e.full;
      end
      check("q_count", q_count, last_qc);
      check("q_full", q_full, last_qf);
    end else begin
      check("q_count_hold", q_count, last_qc);
      check("q_full_hold", q_full, last_qf);
    end
`ifdef GAM_NODE_CNT_TOTAL_EN
    check("total_count", total_count, mtotal);
`endif
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic query(input int c);
    step(0, 0, 0, 0, 0, 0, 1, c);
  endtask

  task automatic inc(input int c);
    step(0, 1, c, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; inc_en = 1'b0; inc_class = '0; dec_en = 1'b0; dec_class = '0;
    clr_all = 1'b0; q_en = 1'b0; q_class = '0;
    @(negedge clk);

    // Reset state, then an empty query
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    query(3);
    idle_cyc();

    // Fill class 5 to the cap, one more is refused, same-class inc+dec at cap
    for (int i = 0; i < MAXN; i++) inc(5);
    inc(5);
    query(5);
    step(0, 1, 5, 1, 5, 0, 1, 5);
    query(5);

    // Underflow at 0, then same-class inc+dec at 0, different classes together
    step(0, 0, 0, 1, 2, 0, 0, 0);
    query(2);
    step(0, 1, 2, 1, 2, 0, 0, 0);
    query(2);
    step(0, 1, 4, 1, 5, 0, 0, 0);
    query(4);
    query(5);

    // All classes at 10, sweep with mid-sweep traffic and queries
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 10; k++) inc(c);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 9, 0, 1, 9);
    step(0, 0, 0, 0, 0, 1, 1, 15);
    for (int i = 0; i < 14; i++) idle_cyc();
    for (int c = 0; c < NC; c++) query(c);

    // Same-cycle write to the queried class is not visible
    for (int i = 0; i < 4; i++) inc(7);
    step(0, 1, 7, 0, 0, 0, 1, 7);
    query(7);
    idle_cyc();

    // Reset in the middle of a sweep
    for (int i = 0; i < 3; i++) inc(3);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle_cyc();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < NC; c++) query(c);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, NC - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, NC - 1)),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, NC - 1)));
    end

    check("q_drain", qq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
